// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: state encoding and parameter defaults.
package pc_sequencer_pkg;
  localparam int          PC_W_DEF     = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_EXEC   = 2'b10,
    ST_HALTED = 2'b11
  } state_e;
endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: branch target when taken, otherwise fall through by one word.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] offset,
  input  logic            branch,
  input  logic            uncond,
  input  logic            zero,
  output logic [PC_W-1:0] nxt
);
  logic taken;

  // Two's-complement offset makes a plain modular add cover backward branches.
  always_comb begin
    taken = (branch & zero) | uncond;
    nxt   = taken ? pc + offset : pc + PC_W'(1);
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: walks the PC through instruction memory, retiring one
// instruction per EXEC, with halt request and fetch-timeout handling.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            instr_valid,
  input  logic            br_valid,
  input  logic            branch,
  input  logic            uncond,
  input  logic            zero,
  input  logic [PC_W-1:0] offset,
  output logic [PC_W-1:0] pc,
  output logic [1:0]      state,
  output logic            fault,
  output logic [31:0]     retired
);
  localparam int          WW   = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] LAST = WW'(MAX_WAIT - 1);

  state_e          st, st_nxt;
  logic [WW-1:0]   wcnt;
  logic            halt_pending;
  logic            timeout, retire;
  logic [PC_W-1:0] pc_nxt;

  pc_next_calc #(.PC_W(PC_W)) u_next (
    .pc     (pc),
    .offset (offset),
    .branch (branch),
    .uncond (uncond),
    .zero   (zero),
    .nxt    (pc_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) st <= ST_IDLE;
    else        st <= st_nxt;
  end

  // An ack on the final permitted wait cycle beats the timeout.
  always_comb begin
    st_nxt  = st;
    timeout = 1'b0;
    retire  = 1'b0;
    case (st)
      ST_IDLE: begin
        if (halt)       st_nxt = ST_HALTED;
        else if (start) st_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) st_nxt = ST_EXEC;
        else if (wcnt == LAST) begin
          st_nxt  = ST_HALTED;
          timeout = 1'b1;
        end
      end
      ST_EXEC: begin
        if (br_valid) begin
          retire = 1'b1;
          st_nxt = (halt_pending | halt) ? ST_HALTED : ST_FETCH;
        end
      end
      default: st_nxt = ST_HALTED;
    endcase
  end

  always_comb begin
    imem_req  = (st == ST_FETCH);
    imem_addr = pc;
    state     = st;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      wcnt         <= '0;
      halt_pending <= 1'b0;
      fault        <= 1'b0;
      retired      <= '0;
      instr_valid  <= 1'b0;
    end else begin
      instr_valid <= (st == ST_FETCH) && imem_ack;
      // Any cycle outside a stalled FETCH leaves the counter clear for the next entry.
      wcnt        <= ((st == ST_FETCH) && !imem_ack) ? wcnt + WW'(1) : '0;
      if (halt && (st == ST_FETCH || st == ST_EXEC)) halt_pending <= 1'b1;
      if (timeout) fault <= 1'b1;
      if (retire) begin
        pc <= pc_nxt;
        if (retired != 32'hFFFF_FFFF) retired <= retired + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized
// instruction stream compared against a simple PC/retire-count model.
module tb_pc_sequencer;
  localparam int PC_W     = 64;
  localparam int MAX_WAIT = 15;

  logic            clk = 1'b0;
  logic            rst_n, start, halt, imem_ack, br_valid, branch, uncond, zero;
  logic [PC_W-1:0] offset;
  logic            imem_req, instr_valid, fault;
  logic [PC_W-1:0] imem_addr, pc;
  logic [1:0]      state;
  logic [31:0]     retired;

  int              total = 0, bad = 0;
  logic [PC_W-1:0] mpc;
  int unsigned     mret;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC('0), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .br_valid(br_valid), .branch(branch),
    .uncond(uncond), .zero(zero), .offset(offset), .pc(pc),
    .state(state), .fault(fault), .retired(retired)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, state=%0d", state);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    start = 0; halt = 0; imem_ack = 0; br_valid = 0;
    branch = 0; uncond = 0; zero = 0; offset = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0; tick(); tick();
    rst_n = 1;
    mpc = '0; mret = 0;
  endtask

  task automatic begin_run();
    start = 1; tick(); start = 0;
  endtask

  // Model: one retirement moves PC by offset if taken, else by one word.
  task automatic model_retire(input logic b, u, z, input logic [PC_W-1:0] off);
    mpc = ((b && z) || u) ? mpc + off : mpc + 1;
    if (mret != 32'hFFFF_FFFF) mret++;
  endtask

  // Stimulus only: stall fetch `waits` cycles, ack, stall exec `xwaits`, retire.
  task automatic retire(input logic b, u, z, input logic [PC_W-1:0] off,
                        input int waits, input int xwaits, input logic h);
    for (int i = 0; i < waits; i++) begin
      br_valid = $urandom_range(0, 1); tick();
    end
    br_valid = 0; imem_ack = 1; tick(); imem_ack = 0;
    for (int i = 0; i < xwaits; i++) begin
      start = 1; tick(); start = 0;
    end
    branch = b; uncond = u; zero = z; offset = off; br_valid = 1; halt = h;
    tick();
    br_valid = 0; halt = 0; branch = 0; uncond = 0; zero = 0;
    model_retire(b, u, z, off);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== 2'b00)     begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (pc !== '0)           begin bad++; $display("FAIL reset_pc got=%0h want=0", pc); end
    total++; if (imem_req !== 1'b0)   begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_iv got=%b want=0", instr_valid); end
    total++; if (fault !== 1'b0)      begin bad++; $display("FAIL reset_fault got=%b want=0", fault); end
    total++; if (retired !== 32'd0)   begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ack = 1; tick(); imem_ack = 0;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL idle_ack_ignored state got=%0d want=0", state); end
    begin_run();
    total++; if (imem_req !== 1'b1 || state !== 2'b01) begin bad++; $display("FAIL start_req req=%b state=%0d want 1/1", imem_req, state); end
    imem_ack = 1; tick(); imem_ack = 0;
    total++; if (instr_valid !== 1'b1 || state !== 2'b10) begin bad++; $display("FAIL iv_pulse iv=%b state=%0d want 1/2", instr_valid, state); end
    tick();
    total++; if (instr_valid !== 1'b0 || state !== 2'b10) begin bad++; $display("FAIL iv_one_cycle iv=%b state=%0d want 0/2", instr_valid, state); end
    br_valid = 1; tick(); br_valid = 0;
    model_retire(0, 0, 0, '0);
    total++; if (pc !== 64'd1) begin bad++; $display("FAIL seq_pc1 got=%0h want=1", pc); end
    for (int k = 2; k <= 3; k++) begin
      retire(0, 0, 0, '0, 0, 0, 0);
      total++; if (pc !== 64'(k)) begin bad++; $display("FAIL seq_pc got=%0h want=%0d", pc, k); end
    end
    total++; if (retired !== 32'd3) begin bad++; $display("FAIL seq_retired got=%0d want=3", retired); end
    total++; if (imem_addr !== 64'd3 || imem_req !== 1'b1) begin bad++; $display("FAIL seq_addr got=%0h/%b want=3/1", imem_addr, imem_req); end
  endtask

  task automatic test_branch();
    do_reset(); begin_run();
    retire(0, 1, 0, 64'd5, 0, 0, 0);
    total++; if (pc !== 64'd5) begin bad++; $display("FAIL br_setup got=%0h want=5", pc); end
    retire(1, 0, 1, -64'd3, 0, 0, 0);
    total++; if (pc !== 64'd2) begin bad++; $display("FAIL br_taken_back got=%0h want=2", pc); end
    retire(0, 1, 0, 64'd3, 0, 0, 0);
    retire(1, 0, 0, -64'd3, 0, 0, 0);
    total++; if (pc !== 64'd6) begin bad++; $display("FAIL br_not_taken got=%0h want=6", pc); end
    retire(0, 1, 0, -64'd1, 0, 0, 0);
    retire(0, 1, 0, 64'd10, 0, 0, 0);
    total++; if (pc !== 64'd15) begin bad++; $display("FAIL br_uncond got=%0h want=15", pc); end
    total++; if (pc !== mpc || retired !== mret) begin bad++; $display("FAIL br_model pc=%0h/%0h ret=%0d/%0d", pc, mpc, retired, mret); end
  endtask

  task automatic test_timeout();
    logic [PC_W-1:0] held;
    do_reset(); begin_run();
    for (int i = 0; i < MAX_WAIT - 1; i++) tick();
    total++; if (state !== 2'b01 || imem_req !== 1'b1) begin bad++; $display("FAIL to_still_fetch state=%0d req=%b want 1/1", state, imem_req); end
    tick();
    total++; if (state !== 2'b11 || fault !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL to_halt state=%0d fault=%b req=%b want 3/1/0", state, fault, imem_req); end
    held = pc;
    start = 1; imem_ack = 1; br_valid = 1; uncond = 1; offset = 64'd7;
    tick(); tick();
    idle_inputs();
    total++; if (state !== 2'b11 || pc !== held || fault !== 1'b1) begin bad++; $display("FAIL halted_frozen state=%0d pc=%0h fault=%b", state, pc, fault); end

    do_reset(); begin_run();
    for (int i = 0; i < MAX_WAIT - 1; i++) tick();
    imem_ack = 1; tick(); imem_ack = 0;
    total++; if (state !== 2'b10 || fault !== 1'b0 || instr_valid !== 1'b1) begin bad++; $display("FAIL to_ack_wins state=%0d fault=%b iv=%b want 2/0/1", state, fault, instr_valid); end
  endtask

  task automatic test_halt();
    do_reset(); begin_run();
    halt = 1; tick(); halt = 0;
    retire(0, 0, 0, '0, 1, 0, 0);
    total++; if (state !== 2'b11 || retired !== 32'd1 || pc !== 64'd1) begin bad++; $display("FAIL halt_fetch state=%0d ret=%0d pc=%0h want 3/1/1", state, retired, pc); end
    for (int i = 0; i < 4; i++) begin
      start = 1; tick(); start = 0;
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_no_req got=%b want=0", imem_req); end
    end
    do_reset(); begin_run();
    retire(0, 1, 0, 64'd9, 0, 2, 1);
    total++; if (state !== 2'b11 || pc !== 64'd9 || retired !== 32'd1) begin bad++; $display("FAIL halt_same_cycle state=%0d pc=%0h ret=%0d want 3/9/1", state, pc, retired); end
    do_reset();
    halt = 1; start = 1; tick(); idle_inputs();
    total++; if (state !== 2'b11 || imem_req !== 1'b0) begin bad++; $display("FAIL halt_idle state=%0d req=%b want 3/0", state, imem_req); end
  endtask

  task automatic test_wrap();
    do_reset(); begin_run();
    retire(0, 1, 0, -64'd1, 0, 0, 0);
    total++; if (pc !== {PC_W{1'b1}}) begin bad++; $display("FAIL wrap_max got=%0h want=ffffffffffffffff", pc); end
    retire(1, 0, 0, 64'd4, 0, 0, 0);
    total++; if (pc !== '0 || fault !== 1'b0 || state !== 2'b01) begin bad++; $display("FAIL wrap_zero pc=%0h fault=%b state=%0d want 0/0/1", pc, fault, state); end
  endtask

  task automatic test_reset_midfetch();
    do_reset(); begin_run();
    retire(0, 0, 0, '0, 0, 0, 0);
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL mid_pre_req got=%b want=1", imem_req); end
    rst_n = 0; tick(); rst_n = 1;
    imem_ack = 1; tick(); imem_ack = 0;
    total++; if (state !== 2'b00 || pc !== '0 || instr_valid !== 1'b0 || retired !== 32'd0) begin bad++; $display("FAIL mid_reset state=%0d pc=%0h iv=%b ret=%0d want 0/0/0/0", state, pc, instr_valid, retired); end
    tick();
    total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL mid_late_ack iv=%b req=%b want 0/0", instr_valid, imem_req); end
  endtask

  task automatic test_random();
    logic b, u, z;
    logic [PC_W-1:0] off;
    do_reset(); begin_run();
    for (int n = 0; n < 200; n++) begin
      b = 1'($urandom); u = ($urandom_range(0, 3) == 0); z = 1'($urandom);
      case ($urandom_range(0, 2))
        0: off = {$urandom, $urandom};
        1: off = 64'($signed($urandom_range(0, 64)) - 32);
        default: off = {PC_W{1'b1}} - 64'($urandom_range(0, 3));
      endcase
      retire(b, u, z, off, $urandom_range(0, MAX_WAIT - 1), $urandom_range(0, 2), 0);
      total++;
      if (pc !== mpc || retired !== mret || imem_addr !== mpc || state !== 2'b01 || fault !== 1'b0) begin
        bad++;
        $display("FAIL rand_%0d pc=%0h/%0h ret=%0d/%0d state=%0d fault=%b", n, pc, mpc, retired, mret, state, fault);
      end
    end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_timeout();
    test_halt();
    test_wrap();
    test_reset_midfetch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
